bsearch_arbiter: RTL

- Shares one successive-approximation binary-search engine between NREQ requesters.
- Each requester presents an unsigned W-bit value. The arbiter grants the engine round-robin, sequences W compare/halve iterations, and returns the converged result tagged with the requester id.
- Sits between the per-channel value sources and the downstream consumer. It replaces free-running per-channel search instances with one time-multiplexed engine that has explicit start and done control.

---
 rtl/bsearch_pkg.sv | 18 +
 rtl/bsearch_if.sv | 29 ++
 rtl/bsearch_core.sv | 56 +++++
 rtl/bsearch_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/bsearch_pkg.sv
// Shared types and defaults for the round-robin binary-search arbiter.
// Imported by the interface, the datapath core and the arbiter top.
package bsearch_pkg;

  localparam int DEF_W    = 8;
  localparam int DEF_NREQ = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_e;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsearch_if.sv
// Request/response bundle between value sources, the arbiter
// and the downstream consumer.
interface bsearch_if
  import bsearch_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) ();
  localparam int IDW = id_w(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] v_in;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [W-1:0]      ans;
  logic [IDW-1:0]    ans_id;
  logic              ans_valid;

  modport master (
    output req, v_in,
    input  ack, busy, ans, ans_id, ans_valid
  );

  modport slave (
    input  req, v_in,
    output ack, busy, ans, ans_id, ans_valid
  );

endinterface

// File: rtl/bsearch_core.sv
// Successive-approximation datapath: W compare/halve steps on [b, e).
// The value is captured on start and ignored afterwards.
module bsearch_core
  import bsearch_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [W-1:0] i_value,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_result
);
  localparam int CW = $clog2(W + 1);
  localparam logic [W:0] TOP = {1'b1, {W{1'b0}}};

  logic [W:0]    r_b;
  logic [W:0]    r_e;
  logic [W:0]    r_val;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [W:0]    w_m;
  logic          w_last;

  // b+e < 2^(W+1) always, so the W+1 bit sum cannot wrap
  assign w_m    = (r_b + r_e) >> 1;
  assign w_last = (r_cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b    <= '0;
      r_e    <= TOP;
      r_val  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_b    <= '0;
      r_e    <= TOP;
      r_val  <= {1'b0, i_value};
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_val >= w_m) r_b <= w_m;
      else              r_e <= w_m;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_busy & w_last;
  assign o_result = r_b[W-1:0];

endmodule

// File: rtl/bsearch_arbiter.sv
// Round-robin front end time-sharing one bsearch_core among NREQ
// requesters; returns each converged result tagged with its id.
module bsearch_arbiter
  import bsearch_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic     clk,
  input  logic     rst,
  bsearch_if.slave bus
);
  localparam int IDW = id_w(NREQ);

  state_e          r_state;
  state_e          w_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [NREQ-1:0] r_ack;
  logic [W-1:0]    r_ans;
  logic [IDW-1:0]  r_ans_id;
  logic            r_ans_valid;

  logic            w_gnt_vld;
  logic [IDW-1:0]  w_gnt;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [NREQ-1:0] w_onehot;
  logic [W-1:0]    w_val;
  logic            w_start;
  logic            w_core_busy;
  logic            w_done;
  logic [W-1:0]    w_result;

  // first set request at or after the pointer, wrapping
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_vld &&
          bus.req[IDW'((int'(r_ptr) + k) % NREQ)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_ptr_nxt = (w_gnt == IDW'(NREQ - 1)) ?
                     '0 : w_gnt + IDW'(1);
  assign w_onehot  = NREQ'(1) << w_gnt;
  assign w_val     = bus.v_in[int'(w_gnt)*W +: W];

  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_nxt   = S_SEARCH;
          w_start = 1'b1;
        end
      end
      S_SEARCH: if (w_done) w_nxt = S_DONE;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_ack       <= '0;
      r_ans       <= '0;
      r_ans_id    <= '0;
      r_ans_valid <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_ack       <= '0;
      r_ans_valid <= 1'b0;
      if (w_start) begin
        r_ack <= w_onehot;
        r_id  <= w_gnt;
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == S_DONE) begin
        r_ans       <= w_result;
        r_ans_id    <= r_id;
        r_ans_valid <= 1'b1;
      end
    end
  end

  bsearch_core #(.W(W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_value  (w_val),
    .o_busy   (w_core_busy),
    .o_done   (w_done),
    .o_result (w_result)
  );

  assign bus.busy      = w_core_busy | (r_state == S_DONE);
  assign bus.ack       = r_ack;
  assign bus.ans       = r_ans;
  assign bus.ans_id    = r_ans_id;
  assign bus.ans_valid = r_ans_valid;

endmodule
